// File: rtl/key_pkg.sv
// rtl/key_pkg.sv - shared types and helpers for the key debounce block
package key_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    PRESS_FILT = 2'd1,
    DOWN       = 2'd2,
    REL_FILT   = 2'd3
  } key_fsm_e;

  function automatic int ms_to_cyc(input int clk_hz, input int ms);
    return clk_hz / 1000 * ms;
  endfunction

  function automatic int cnt_width(input int max_val);
    return (max_val < 2) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/key_debounce_ch.sv
// rtl/key_debounce_ch.sv - one key channel: synchroniser, debounce FSM, long-press counter
module key_debounce_ch
  import key_pkg::*;
#(
  parameter int DB_CYC   = 5,
  parameter int LONG_CYC = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic key_n,
  output logic key_state,
  output logic key_press,
  output logic key_release,
  output logic key_long
);

  localparam int CW = cnt_width(LONG_CYC);
  localparam logic [CW-1:0] DB_LAST   = CW'(DB_CYC - 1);
  localparam logic [CW-1:0] LONG_LAST = CW'(LONG_CYC - 1);
  localparam logic [CW-1:0] LONG_MAX  = CW'(LONG_CYC);

  logic [1:0]    sync_q;
  logic          s;
  key_fsm_e      state, state_nxt;
  logic [CW-1:0] db_cnt, db_cnt_nxt;
  logic [CW-1:0] long_cnt, long_cnt_nxt;
  logic          press_nxt, release_nxt, long_nxt;

  assign s = sync_q[1];

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q      <= 2'b00;
      state       <= IDLE;
      db_cnt      <= '0;
      long_cnt    <= '0;
      key_state   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
      key_long    <= 1'b0;
    end else begin
      sync_q      <= {sync_q[0], ~key_n};
      state       <= state_nxt;
      db_cnt      <= db_cnt_nxt;
      long_cnt    <= long_cnt_nxt;
      key_state   <= (state_nxt == DOWN) || (state_nxt == REL_FILT);
      key_press   <= press_nxt;
      key_release <= release_nxt;
      key_long    <= long_nxt;
    end
  end

  // The long counter keeps running through a release filter so a short
  // release glitch does not shift the long-press event.
  always_comb begin
    state_nxt    = state;
    db_cnt_nxt   = db_cnt;
    long_cnt_nxt = long_cnt;
    press_nxt    = 1'b0;
    release_nxt  = 1'b0;
    long_nxt     = 1'b0;
    unique case (state)
      IDLE: begin
        db_cnt_nxt   = '0;
        long_cnt_nxt = '0;
        if (s) state_nxt = PRESS_FILT;
      end
      PRESS_FILT: begin
        if (!s) begin
          state_nxt = IDLE;
        end else if (db_cnt == DB_LAST) begin
          state_nxt    = DOWN;
          press_nxt    = 1'b1;
          db_cnt_nxt   = '0;
          long_cnt_nxt = '0;
        end else begin
          db_cnt_nxt = db_cnt + 1'b1;
        end
      end
      DOWN: begin
        if (long_cnt != LONG_MAX) long_cnt_nxt = long_cnt + 1'b1;
        if (long_cnt == LONG_LAST) long_nxt = 1'b1;
        if (!s) begin
          state_nxt  = REL_FILT;
          db_cnt_nxt = '0;
        end
      end
      REL_FILT: begin
        if (long_cnt != LONG_MAX) long_cnt_nxt = long_cnt + 1'b1;
        if (s) begin
          state_nxt = DOWN;
        end else if (db_cnt == DB_LAST) begin
          state_nxt   = IDLE;
          release_nxt = 1'b1;
        end else begin
          db_cnt_nxt = db_cnt + 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule

// File: rtl/key_debounce_scan.sv
// rtl/key_debounce_scan.sv - parallel debounce of N_KEYS active-low push buttons
module key_debounce_scan
  import key_pkg::*;
#(
  parameter int N_KEYS      = 4,
  parameter int CLK_HZ      = 50_000_000,
  parameter int DEBOUNCE_MS = 20,
  parameter int LONG_MS     = 1000
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [N_KEYS-1:0] key_n,
  output logic [N_KEYS-1:0] key_state,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic [N_KEYS-1:0] key_long
);

  localparam int DB_CYC   = ms_to_cyc(CLK_HZ, DEBOUNCE_MS);
  localparam int LONG_CYC = ms_to_cyc(CLK_HZ, LONG_MS);

  if (DEBOUNCE_MS < 1 || LONG_MS <= DEBOUNCE_MS || N_KEYS < 1 || N_KEYS > 8) begin : g_param_check
    $fatal(1, "key_debounce_scan: need 1 <= N_KEYS <= 8 and LONG_MS > DEBOUNCE_MS >= 1");
  end

  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    key_debounce_ch #(
      .DB_CYC  (DB_CYC),
      .LONG_CYC(LONG_CYC)
    ) u_ch (
      .clk        (clk),
      .rst        (rst),
      .key_n      (key_n[i]),
      .key_state  (key_state[i]),
      .key_press  (key_press[i]),
      .key_release(key_release[i]),
      .key_long   (key_long[i])
    );
  end

endmodule

// File: tb/tb_key_debounce_scan.sv
// tb/tb_key_debounce_scan.sv - randomized and directed bench for key_debounce_scan
module tb_key_debounce_scan;

  localparam int N        = 4;
  localparam int DB_CYC   = 5;
  localparam int LONG_CYC = 20;
  localparam int P_AT     = 3 + DB_CYC;  // tick index of press when raw edge is sampled at tick 1

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] key_n = '1;
  logic [N-1:0] key_state, key_press, key_release, key_long;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Reference model: a level is accepted after DB_CYC+1 consecutive synced
  // samples disagreeing with it; long fires LONG_CYC edges after the press if
  // the key is then held with no pending release sample.
  bit           p1 [N];
  bit           p2 [N];
  bit           lvl[N];
  int           run[N];
  int           press_cyc[N];
  logic [N-1:0] m_state = '0, m_press = '0, m_rel = '0, m_long = '0;

  key_debounce_scan #(
    .N_KEYS     (N),
    .CLK_HZ     (1000),
    .DEBOUNCE_MS(5),
    .LONG_MS    (20)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .key_n      (key_n),
    .key_state  (key_state),
    .key_press  (key_press),
    .key_release(key_release),
    .key_long   (key_long)
  );

  always #5 clk = ~clk;

  task automatic tick();
    bit s;
    @(posedge clk);
    cyc++;
    m_press = '0;
    m_rel   = '0;
    m_long  = '0;
    for (int k = 0; k < N; k++) begin
      if (rst) begin
        p1[k] = 0; p2[k] = 0; lvl[k] = 0; run[k] = 0;
      end else begin
        s     = p2[k];
        p2[k] = p1[k];
        p1[k] = ~key_n[k];
        if (lvl[k] && run[k] == 0 && cyc - press_cyc[k] == LONG_CYC) m_long[k] = 1'b1;
        if (s != lvl[k]) begin
          run[k]++;
          if (run[k] == DB_CYC + 1) begin
            lvl[k] = s;
            run[k] = 0;
            if (s) begin
              m_press[k]   = 1'b1;
              press_cyc[k] = cyc;
            end else begin
              m_rel[k] = 1'b1;
            end
          end
        end else begin
          run[k] = 0;
        end
      end
      m_state[k] = lvl[k];
    end
    #1;
  endtask

  task automatic test_reset();
    rst   = 1'b1;
    key_n = '1;
    repeat (3) tick();
    n_checks++;
    if ({key_state, key_press, key_release, key_long} !== 16'h0) begin
      n_fail++; $display("FAIL reset_outputs: got %h want 0000", {key_state, key_press, key_release, key_long});
    end
    rst = 1'b0;
    repeat (4) tick();
    n_checks++;
    if ({key_state, key_press, key_release, key_long} !== 16'h0) begin
      n_fail++; $display("FAIL reset_idle: got %h want 0000", {key_state, key_press, key_release, key_long});
    end
  endtask

  task automatic test_clean_press();
    for (int i = 1; i <= 40 + P_AT + 2; i++) begin
      key_n[0] = (i <= 40) ? 1'b0 : 1'b1;
      tick();
      n_checks++;
      if ({key_state, key_press, key_release, key_long} !== {m_state, m_press, m_rel, m_long}) begin
        n_fail++; $display("FAIL clean_model cyc %0d: got %h want %h", cyc, {key_state, key_press, key_release, key_long}, {m_state, m_press, m_rel, m_long});
      end
      n_checks++;
      if (key_press[0] !== (i == P_AT)) begin
        n_fail++; $display("FAIL clean_press tick %0d: got %b want %b", i, key_press[0], i == P_AT);
      end
      n_checks++;
      if (key_long[0] !== (i == P_AT + LONG_CYC)) begin
        n_fail++; $display("FAIL clean_long tick %0d: got %b want %b", i, key_long[0], i == P_AT + LONG_CYC);
      end
      n_checks++;
      if (key_state[0] !== (i >= P_AT && i < 40 + P_AT)) begin
        n_fail++; $display("FAIL clean_state tick %0d: got %b", i, key_state[0]);
      end
      n_checks++;
      if (key_release[0] !== (i == 40 + P_AT)) begin
        n_fail++; $display("FAIL clean_release tick %0d: got %b", i, key_release[0]);
      end
    end
  endtask

  task automatic test_bounce();
    for (int i = 1; i <= 20; i++) begin
      key_n[1] = (i <= 3) ? 1'b0 : (i <= 5) ? 1'b1 : (i <= 8) ? 1'b0 : 1'b1;
      tick();
      n_checks++;
      if ({key_state, key_press, key_release, key_long} !== {m_state, m_press, m_rel, m_long}) begin
        n_fail++; $display("FAIL bounce_model cyc %0d: got %h want %h", cyc, {key_state, key_press, key_release, key_long}, {m_state, m_press, m_rel, m_long});
      end
      n_checks++;
      if ({key_state[1], key_press[1]} !== 2'b00) begin
        n_fail++; $display("FAIL bounce_no_event tick %0d: got state=%b press=%b want 0 0", i, key_state[1], key_press[1]);
      end
    end
  endtask

  task automatic test_release_glitch();
    for (int i = 1; i <= 62; i++) begin
      key_n[2] = (i <= 12) ? 1'b0 : (i <= 14) ? 1'b1 : (i <= 49) ? 1'b0 : 1'b1;
      tick();
      n_checks++;
      if ({key_state, key_press, key_release, key_long} !== {m_state, m_press, m_rel, m_long}) begin
        n_fail++; $display("FAIL release_model cyc %0d: got %h want %h", cyc, {key_state, key_press, key_release, key_long}, {m_state, m_press, m_rel, m_long});
      end
      n_checks++;
      if ({key_press[2], key_long[2], key_release[2]} !== {i == P_AT, i == P_AT + LONG_CYC, i == 57}) begin
        n_fail++; $display("FAIL release_events tick %0d: got p/l/r=%b%b%b", i, key_press[2], key_long[2], key_release[2]);
      end
      n_checks++;
      if (key_state[2] !== (i >= P_AT && i < 57)) begin
        n_fail++; $display("FAIL release_state tick %0d: got %b", i, key_state[2]);
      end
    end
  endtask

  task automatic test_short_press();
    for (int i = 1; i <= 40; i++) begin
      key_n[3] = (i <= P_AT + 9) ? 1'b0 : 1'b1;
      tick();
      n_checks++;
      if ({key_state, key_press, key_release, key_long} !== {m_state, m_press, m_rel, m_long}) begin
        n_fail++; $display("FAIL short_model cyc %0d: got %h want %h", cyc, {key_state, key_press, key_release, key_long}, {m_state, m_press, m_rel, m_long});
      end
      n_checks++;
      if ({key_long[3], key_release[3]} !== {1'b0, i == P_AT + 10 + 2 + DB_CYC}) begin
        n_fail++; $display("FAIL short_events tick %0d: got long=%b rel=%b", i, key_long[3], key_release[3]);
      end
    end
  endtask

  task automatic test_simultaneous();
    for (int i = 1; i <= 24; i++) begin
      key_n = (i <= 12) ? 4'b0110 : 4'b1111;
      tick();
      n_checks++;
      if ({key_state, key_press, key_release, key_long} !== {m_state, m_press, m_rel, m_long}) begin
        n_fail++; $display("FAIL simul_model cyc %0d: got %h want %h", cyc, {key_state, key_press, key_release, key_long}, {m_state, m_press, m_rel, m_long});
      end
      n_checks++;
      if (key_press !== ((i == P_AT) ? 4'b1001 : 4'b0000)) begin
        n_fail++; $display("FAIL simul_press tick %0d: got %b", i, key_press);
      end
      n_checks++;
      if (key_release !== ((i == 13 + 2 + DB_CYC) ? 4'b1001 : 4'b0000)) begin
        n_fail++; $display("FAIL simul_release tick %0d: got %b", i, key_release);
      end
    end
  endtask

  task automatic test_reset_mid_press();
    for (int i = 1; i <= 40; i++) begin
      key_n[0] = (i <= 30) ? 1'b0 : 1'b1;
      rst      = (i == 12);
      tick();
      n_checks++;
      if ({key_state, key_press, key_release, key_long} !== {m_state, m_press, m_rel, m_long}) begin
        n_fail++; $display("FAIL rstmid_model cyc %0d: got %h want %h", cyc, {key_state, key_press, key_release, key_long}, {m_state, m_press, m_rel, m_long});
      end
      n_checks++;
      if (key_press[0] !== (i == P_AT || i == 12 + P_AT)) begin
        n_fail++; $display("FAIL rstmid_press tick %0d: got %b", i, key_press[0]);
      end
      n_checks++;
      if (key_release[0] !== (i == 31 + 2 + DB_CYC)) begin
        n_fail++; $display("FAIL rstmid_release tick %0d: got %b", i, key_release[0]);
      end
      if (i == 12) begin
        n_checks++;
        if ({key_state, key_press, key_release, key_long} !== 16'h0) begin
          n_fail++; $display("FAIL rstmid_cleared: got %h want 0000", {key_state, key_press, key_release, key_long});
        end
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_random();
    int hold[N];
    for (int k = 0; k < N; k++) hold[k] = 0;
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < N; k++) begin
        if (hold[k] == 0) begin
          key_n[k] = $urandom_range(0, 1);
          hold[k]  = ($urandom_range(0, 3) == 0) ? $urandom_range(DB_CYC, 30) : $urandom_range(1, DB_CYC + 2);
        end
        hold[k]--;
      end
      rst = ($urandom_range(0, 399) == 0);
      tick();
      n_checks++;
      if ({key_state, key_press, key_release, key_long} !== {m_state, m_press, m_rel, m_long}) begin
        n_fail++; $display("FAIL random_model cyc %0d: got %h want %h", cyc, {key_state, key_press, key_release, key_long}, {m_state, m_press, m_rel, m_long});
      end
    end
    rst   = 1'b0;
    key_n = '1;
    repeat (12) tick();
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_bounce();
    test_release_glitch();
    test_short_press();
    test_simultaneous();
    test_reset_mid_press();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
